matrix_scan_ctrl: RTL and testbench
===================================

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 SHALL have parameters: COLS, default 64, pixels shifted per row pair.
REQ-002 SHALL have parameters: ROWS, default 16, row addresses per frame.
REQ-003 SHALL have parameters: DWELL, default 128, DISPLAY cycles per row, multiple of 8.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports: en  in  1  scan enable (level).
REQ-007 SHALL have ports: swap_req  in  1  frame-buffer swap request, held until swap_ack.
REQ-008 SHALL have ports: bright  in  3  brightness 0..7 (present only with SCAN_DIM_EN).
REQ-009 SHALL have ports: col_idx  out  clog2(COLS)  pixel column to fetch.
REQ-010 SHALL have ports: row_idx  out  clog2(ROWS)  row pair being fetched/shifted.
REQ-011 SHALL have ports: shift_en  out  1  fetched pixel valid on R0..B1 this cycle.
REQ-012 SHALL have ports: abcd  out  4  panel row address {D,C,B,A}.
REQ-013 SHALL have ports: OE  out  1  panel output enable, active-low (1 = blank).
REQ-014 SHALL have ports: LAT  out  1  panel latch strobe.
REQ-015 SHALL have ports: frame_start, frame_done, swap_ack  out  1 each  single-cycle pulses.
REQ-016 SHALL have ports: buf_sel  out  1  frame buffer currently displayed.

Function
REQ-017 SHALL implement FSM IDLE -> SHIFT -> BLANK -> LATCH -> DISPLAY -> (SHIFT | IDLE), all outputs registered.
REQ-018 IDLE: OE=1, LAT=0, shift_en=0; en=1 -> SHIFT with col_idx=0, row_idx=0, frame_start pulsed on that entry cycle.
REQ-019 SHIFT lasts exactly COLS cycles, col_idx 0..COLS-1; shift_en = state==SHIFT delayed 1 cycle (fetch latency 1), so its last high cycle falls in BLANK.
REQ-020 BLANK: 1 cycle, OE=1; LATCH: 1 cycle, LAT=1, abcd <= row_idx; OE=1 throughout SHIFT, BLANK, LATCH.
REQ-021 DISPLAY lasts DWELL cycles; row period therefore COLS+2+DWELL (194 at defaults).
REQ-022 DISPLAY exit: row_idx wraps ROWS-1 -> 0; on wrap frame_done pulses; en=1 -> SHIFT, en=0 -> IDLE.
REQ-023 en deasserted mid-row SHALL complete current row (through DISPLAY) before IDLE; the next enable restarts at row 0.
REQ-024 swap_req sampled only at frame_done cycle; if high, swap_ack pulses and buf_sel toggles in that same cycle.
REQ-025 In IDLE, swap_req=1 SHALL be acked the following cycle with buf_sel toggled; the same request is never acked twice.
REQ-026 frame_done and frame_start SHALL not coincide; frame_start pulses on every row-0 SHIFT entry.

Reset
REQ-027 rst=1 at any clock edge, including mid-SHIFT/DISPLAY, SHALL force IDLE, OE=1, LAT=0, shift_en=0, col_idx=0, row_idx=0, abcd=0, buf_sel=0, all pulses 0.

Configuration
REQ-028 SCAN_DIM_EN defined: OE=0 only for first (bright+1)*DWELL/8 DISPLAY cycles, OE=1 for remainder; bright sampled on LATCH cycle.
REQ-029 SCAN_DIM_EN undefined: bright port absent, OE=0 for all DWELL cycles.

Structure
REQ-030 Package matrix_pkg SHALL hold COLS/ROWS/DWELL defaults and the FSM state encoding.
REQ-031 One sub-module, scan_dwell_timer, SHALL count DISPLAY cycles and produce the dim OE window.

Verification
REQ-032 en=1 from reset, defaults: frame_start at first SHIFT, 64 shift_en, LAT at cycle 66 of row, frame_done after 16x194 cycles.
REQ-033 swap_req raised at row 5: swap_ack + buf_sel 0->1 exactly at frame_done, none earlier.
REQ-034 en dropped during row 7 SHIFT: row 7 DISPLAY completes, IDLE with OE=1; re-enable -> frame_start, row_idx=0.
REQ-035 rst pulsed mid-DISPLAY row 9: next cycle all outputs at reset values, OE=1.
REQ-036 SCAN_DIM_EN, bright=3: OE low 64 of 128 DISPLAY cycles; bright=7: 128; bright=0: 16.
REQ-037 swap_req in IDLE: swap_ack next cycle, buf_sel toggles once while request held.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared defaults and scan FSM state encoding for the LED matrix scan controller.
package matrix_pkg;

   localparam int unsigned COLS_DEF  = 64;
   localparam int unsigned ROWS_DEF  = 16;
   localparam int unsigned DWELL_DEF = 128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_BLANK,
      S_LATCH,
      S_DISPLAY
   } scanState_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Counts DISPLAY cycles of one row and provides the look-ahead flags the
// scan FSM needs to register OE and frame_done on the right cycle.
module scan_dwell_timer
   import matrix_pkg::*;
#(
   parameter int unsigned DWELL = DWELL_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       run,
   input  logic [2:0] bright,
   output logic       winNext,
   output logic       lastNext,
   output logic       last
);

   localparam int unsigned CW = $clog2(DWELL + 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] window;

   // Window length is captured once per row so a brightness change never tears a row.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         window <= '0;
      end else if (load) begin
         cnt    <= '0;
         window <= CW'((32'(bright) + 32'd1) * (DWELL / 32'd8));
      end else if (run) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign winNext  = (cnt + CW'(1)) < window;
   assign lastNext = (cnt == CW'(DWELL - 2));
   assign last     = (cnt == CW'(DWELL - 1));

endmodule

// File: rtl/matrix_scan_ctrl.sv
// HUB75-style row scan controller: shift, blank, latch, display per row pair.
// Define SCAN_DIM_EN to add the bright port and the dimmed OE window.
module matrix_scan_ctrl
   import matrix_pkg::*;
#(
   parameter int unsigned COLS  = COLS_DEF,
   parameter int unsigned ROWS  = ROWS_DEF,
   parameter int unsigned DWELL = DWELL_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    swap_req,
`ifdef SCAN_DIM_EN
   input  logic [2:0]              bright,
`endif
   output logic [$clog2(COLS)-1:0] col_idx,
   output logic [$clog2(ROWS)-1:0] row_idx,
   output logic                    shift_en,
   output logic [3:0]              abcd,
   output logic                    OE,
   output logic                    LAT,
   output logic                    frame_start,
   output logic                    frame_done,
   output logic                    swap_ack,
   output logic                    buf_sel
);

   localparam int unsigned CW = $clog2(COLS);
   localparam int unsigned RW = $clog2(ROWS);

   scanState_t state;
   logic       ackDone;
   logic       swapTake;
   logic       winNext;
   logic       lastNext;
   logic       last;
   logic [2:0] dimLevel;

`ifdef SCAN_DIM_EN
   assign dimLevel = bright;
`else
   assign dimLevel = 3'd7;
`endif

   // ackDone stops a request that is still held from being acknowledged twice.
   assign swapTake = swap_req && !ackDone;

   scan_dwell_timer #(.DWELL(DWELL)) u_dwell (
      .clk     (clk),
      .rst     (rst),
      .load    (state == S_LATCH),
      .run     (state == S_DISPLAY),
      .bright  (dimLevel),
      .winNext (winNext),
      .lastNext(lastNext),
      .last    (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         col_idx     <= '0;
         row_idx     <= '0;
         shift_en    <= 1'b0;
         abcd        <= '0;
         OE          <= 1'b1;
         LAT         <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         swap_ack    <= 1'b0;
         buf_sel     <= 1'b0;
         ackDone     <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         swap_ack    <= 1'b0;
         LAT         <= 1'b0;
         shift_en    <= (state == S_SHIFT);
         if (!swap_req) ackDone <= 1'b0;
         case (state)
            S_IDLE: begin
               OE <= 1'b1;
               if (swapTake) begin
                  swap_ack <= 1'b1;
                  buf_sel  <= !buf_sel;
                  ackDone  <= 1'b1;
               end
               if (en) begin
                  state       <= S_SHIFT;
                  col_idx     <= '0;
                  row_idx     <= '0;
                  frame_start <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (col_idx == CW'(COLS - 1)) begin
                  col_idx <= '0;
                  state   <= S_BLANK;
               end else begin
                  col_idx <= col_idx + CW'(1);
               end
            end
            S_BLANK: begin
               LAT   <= 1'b1;
               abcd  <= 4'(row_idx);
               state <= S_LATCH;
            end
            S_LATCH: begin
               OE    <= 1'b0;
               state <= S_DISPLAY;
            end
            S_DISPLAY: begin
               OE <= !winNext;
               // frame_done is raised one cycle early so it lands on the final DISPLAY cycle.
               if (lastNext && row_idx == RW'(ROWS - 1)) begin
                  frame_done <= 1'b1;
                  if (swapTake) begin
                     swap_ack <= 1'b1;
                     buf_sel  <= !buf_sel;
                     ackDone  <= 1'b1;
                  end
               end
               if (last) begin
                  OE <= 1'b1;
                  if (row_idx == RW'(ROWS - 1) || !en) row_idx <= '0;
                  else row_idx <= row_idx + RW'(1);
                  if (en) begin
                     state       <= S_SHIFT;
                     frame_start <= (row_idx == RW'(ROWS - 1));
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl against a row-position reference model.
module tb_matrix_scan_ctrl;

   localparam int unsigned COLS  = 64;
   localparam int unsigned ROWS  = 16;
   localparam int unsigned DWELL = 128;
   localparam int unsigned P     = COLS + 2 + DWELL;
   localparam int unsigned CW    = $clog2(COLS);
   localparam int unsigned RW    = $clog2(ROWS);
`ifdef SCAN_DIM_EN
   localparam bit DIM = 1'b1;
`else
   localparam bit DIM = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          swap_req;
   logic [2:0]    bright;
   logic [CW-1:0] col_idx;
   logic [RW-1:0] row_idx;
   logic          shift_en;
   logic [3:0]    abcd;
   logic          OE;
   logic          LAT;
   logic          frame_start;
   logic          frame_done;
   logic          swap_ack;
   logic          buf_sel;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit holdReq;

   // Reference model: position within the row period instead of FSM states.
   bit mRun, mBuf, mAck, mAckDone;
   int mRow, mPos, mAbcd, mWin;

   always #5 clk = ~clk;

   matrix_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .DWELL(DWELL)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .swap_req   (swap_req),
`ifdef SCAN_DIM_EN
      .bright     (bright),
`endif
      .col_idx    (col_idx),
      .row_idx    (row_idx),
      .shift_en   (shift_en),
      .abcd       (abcd),
      .OE         (OE),
      .LAT        (LAT),
      .frame_start(frame_start),
      .frame_done (frame_done),
      .swap_ack   (swap_ack),
      .buf_sel    (buf_sel)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic modelEdge();
      bit prevIdle, take, fdNext;
      if (rst) begin
         mRun = 0; mRow = 0; mPos = 0; mAbcd = 0; mWin = 0;
         mBuf = 0; mAck = 0; mAckDone = 0;
         return;
      end
      prevIdle = !mRun;
      take     = swap_req && !mAckDone;
      if (mRun && mPos == COLS) mAbcd = mRow % 16;
      if (mRun && mPos == COLS + 1) mWin = DIM ? (int'(bright) + 1) * DWELL / 8 : DWELL;
      if (!mRun) begin
         if (en) begin mRun = 1; mRow = 0; mPos = 0; end
      end else if (mPos == P - 1) begin
         mRow = (mRow == ROWS - 1) ? 0 : mRow + 1;
         if (en) mPos = 0;
         else begin mRun = 0; mRow = 0; mPos = 0; end
      end else begin
         mPos++;
      end
      fdNext = mRun && mRow == ROWS - 1 && mPos == P - 1;
      mAck   = take && (prevIdle || fdNext);
      if (mAck) mBuf = !mBuf;
      if (!swap_req) mAckDone = 0;
      else if (mAck) mAckDone = 1;
   endtask

   task automatic checkAll();
      chk("col_idx", col_idx, (mRun && mPos < COLS) ? mPos : 0);
      chk("row_idx", row_idx, mRow);
      chk("shift_en", shift_en, mRun && mPos >= 1 && mPos <= COLS);
      chk("abcd", abcd, mAbcd);
      chk("OE", OE, !(mRun && mPos >= COLS + 2 && (mPos - (COLS + 2)) < mWin));
      chk("LAT", LAT, mRun && mPos == COLS + 1);
      chk("frame_start", frame_start, mRun && mRow == 0 && mPos == 0);
      chk("frame_done", frame_done, mRun && mRow == ROWS - 1 && mPos == P - 1);
      chk("swap_ack", swap_ack, mAck);
      chk("buf_sel", buf_sel, mBuf);
      chk("fs_fd_overlap", frame_start & frame_done, 0);
   endtask

   task automatic step();
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
      cyc++;
      if (!holdReq && swap_ack) swap_req = 1'b0;
   endtask

   task automatic runUntil(input int r, input int p);
      int n = 0;
      while (!(mRun && mRow == r && mPos == p) && n < 2 * ROWS * P) begin
         step();
         n++;
      end
      chk("run_until_bound", n < 2 * ROWS * P, 1);
   endtask

   initial begin
      int c0, fsCyc, latCyc, fdCyc, ackCyc, shCnt, lowCnt, acks, firstAck;
      int bl[3];
      rst = 1'b1; en = 1'b0; swap_req = 1'b0; bright = 3'd7; holdReq = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();

      // Full frame from reset, with a swap request raised during row 5.
      en = 1'b1;
      c0 = cyc; fsCyc = -1; latCyc = -1; fdCyc = -1; ackCyc = -1; shCnt = 0;
      for (int i = 0; i < int'(ROWS * P) + 4; i++) begin
         if (i == int'(5 * P)) swap_req = 1'b1;
         step();
         if (i < int'(P) && shift_en) shCnt++;
         if (frame_start && fsCyc < 0) fsCyc = cyc;
         if (LAT && latCyc < 0) latCyc = cyc;
         if (frame_done && fdCyc < 0) fdCyc = cyc;
         if (swap_ack && ackCyc < 0) ackCyc = cyc;
      end
      chk("first_frame_start", fsCyc, c0 + 1);
      chk("shift_count", shCnt, COLS);
      chk("lat_position", latCyc - fsCyc + 1, COLS + 2);
      chk("frame_length", fdCyc - fsCyc + 1, ROWS * P);
      chk("ack_at_frame_done", ackCyc, fdCyc);
      chk("buf_sel_swapped", buf_sel, 1);

      // Drop enable during row 7 SHIFT: the row must still display fully.
      runUntil(7, 10);
      en = 1'b0;
      lowCnt = 0;
      for (int i = 0; i < int'(P) + 4; i++) begin
         step();
         if (!OE) lowCnt++;
      end
      chk("row7_dwell", lowCnt, DWELL);
      chk("idle_OE", OE, 1);
      chk("idle_shift_en", shift_en, 0);
      en = 1'b1;
      step();
      chk("restart_frame_start", frame_start, 1);
      chk("restart_row", row_idx, 0);
      chk("restart_col", col_idx, 0);

      // Reset in the middle of row 9 DISPLAY.
      runUntil(9, COLS + 2 + 20);
      rst = 1'b1; en = 1'b0;
      step();
      chk("rst_OE", OE, 1);
      chk("rst_LAT", LAT, 0);
      chk("rst_shift_en", shift_en, 0);
      chk("rst_row", row_idx, 0);
      chk("rst_abcd", abcd, 0);
      chk("rst_buf_sel", buf_sel, 0);
      rst = 1'b0;
      step();

      // Swap request in IDLE held for several cycles.
      holdReq = 1'b1; swap_req = 1'b1; acks = 0; firstAck = -1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (swap_ack) begin
            acks++;
            if (firstAck < 0) firstAck = i;
         end
      end
      chk("idle_ack_count", acks, 1);
      chk("idle_ack_latency", firstAck, 0);
      chk("idle_buf_sel", buf_sel, 1);
      swap_req = 1'b0; holdReq = 1'b0;
      step();

`ifdef SCAN_DIM_EN
      bl = '{3, 7, 0};
      en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bright = 3'(bl[k]);
         step();
         runUntil(mRow == int'(ROWS) - 1 ? 0 : mRow + 1, 0);
         lowCnt = 0;
         for (int i = 0; i < int'(P); i++) begin
            step();
            if (!OE) lowCnt++;
         end
         chk("dim_low_cycles", lowCnt, (bl[k] + 1) * int'(DWELL) / 8);
      end
`else
      bl = '{0, 0, 0};
      bright = 3'(bl[0]);
`endif

      // Randomized enable, swap handshakes, brightness and occasional reset.
      en = 1'b1;
      for (int i = 0; i < 9000; i++) begin
         if (en) begin
            if ($urandom_range(0, 1999) == 0) en = 1'b0;
         end else if ($urandom_range(0, 49) == 0) begin
            en = 1'b1;
         end
         if (!swap_req && $urandom_range(0, 99) == 0) swap_req = 1'b1;
         rst    = ($urandom_range(0, 2999) == 0);
         bright = 3'($urandom_range(0, 7));
         step();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
